// File: rtl/mcp_pkg.sv
// Shared constants and helpers for the multicycle-adder issue controller.
// Defaults match the 2-cycle MCP wide adder.
package mcp_pkg;

    localparam int WIDTH        = 64;
    localparam int II           = 2;
    localparam int LATENCY      = 3;
    localparam int RESULT_DEPTH = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int CNT_W = clog2(RESULT_DEPTH + 1);

endpackage

// File: rtl/mcp_issue_ctrl_if.sv
// Operand stream, adder issue bus and result stream of the feeder.
// master = surrounding system, slave = mcp_issue_ctrl.
interface mcp_issue_ctrl_if #(
    parameter int WIDTH = mcp_pkg::WIDTH
) ();

    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_a;
    logic [WIDTH-1:0] s_b;
    logic             adder_en;
    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_b;
    logic [WIDTH-1:0] adder_sum;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_sum;
    logic             busy;

    modport master (
        output s_valid, s_a, s_b, adder_sum, m_ready,
        input  s_ready, adder_en, adder_a, adder_b, m_valid, m_sum, busy
    );

    modport slave (
        input  s_valid, s_a, s_b, adder_sum, m_ready,
        output s_ready, adder_en, adder_a, adder_b, m_valid, m_sum, busy
    );

endinterface

// File: rtl/mcp_result_fifo.sv
// First-word-fall-through result FIFO with a registered head output.
// The head register is refreshed with forwarding so a write to an empty FIFO shows next cycle.
module mcp_result_fifo #(
    parameter int WIDTH = mcp_pkg::WIDTH,
    parameter int DEPTH = mcp_pkg::RESULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    import mcp_pkg::*;

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dout;

    logic             w_rd;
    logic [PW-1:0]    w_rp_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_head;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_rdata = r_dout;

    // next read pointer, occupancy and head value (write forwarded into an emptied head)
    always_comb begin
        w_rd      = i_rd_en && !o_empty;
        w_rp_nxt  = w_rd ? r_rp + 1'b1 : r_rp;
        w_cnt_nxt = r_cnt + CW'(i_wr_en) - CW'(w_rd);
        w_head    = r_mem[w_rp_nxt];
        if (i_wr_en && (r_wp == w_rp_nxt)) w_head = i_wdata;
    end

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[r_wp] <= i_wdata;
    end

    // pointers, occupancy and registered head; head holds while the FIFO is empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
        end else begin
            if (i_wr_en) r_wp <= r_wp + 1'b1;
            r_rp  <= w_rp_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt != '0) r_dout <= w_head;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(i_wr_en && o_full && !i_rd_en)
    );

endmodule

// File: rtl/mcp_issue_ctrl.sv
// Issue controller for the multicycle wide adder: paced issue, held operands,
// fixed-latency capture into a result FIFO, credit limit against FIFO overflow.
module mcp_issue_ctrl #(
    parameter int WIDTH        = mcp_pkg::WIDTH,
    parameter int II           = mcp_pkg::II,
    parameter int LATENCY      = mcp_pkg::LATENCY,
    parameter int RESULT_DEPTH = mcp_pkg::RESULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    mcp_issue_ctrl_if.slave  bus
);
    import mcp_pkg::*;

    localparam int C_W    = clog2(RESULT_DEPTH + 1);
    localparam int COOL_W = clog2(II + 1);

    logic              r_sready;
    logic [COOL_W-1:0] r_cool;
    logic [C_W-1:0]    r_cred;
    logic [LATENCY:0]  r_mark;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;

    logic              w_acc;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [COOL_W-1:0] w_cool_nxt;
    logic [C_W-1:0]    w_cred_nxt;

    assign w_acc = bus.s_valid && r_sready;
    assign w_pop = !w_empty && bus.m_ready;

    assign bus.s_ready  = r_sready;
    assign bus.adder_en = r_mark[0];
    assign bus.adder_a  = r_a;
    assign bus.adder_b  = r_b;
    assign bus.m_valid  = !w_empty;
    assign bus.busy     = (r_cred != '0);

    // next cooldown and credit values
    always_comb begin
        w_cool_nxt = r_cool;
        if (w_acc) w_cool_nxt = COOL_W'(II - 1);
        else if (r_cool != '0) w_cool_nxt = r_cool - 1'b1;
        w_cred_nxt = r_cred;
        unique case ({w_acc, w_pop})
            2'b10:   w_cred_nxt = r_cred + 1'b1;
            2'b01:   w_cred_nxt = r_cred - 1'b1;
            default: w_cred_nxt = r_cred;
        endcase
    end

    // pacing, credits, in-flight markers and held operands; s_ready registered from next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sready <= 1'b0;
            r_cool   <= '0;
            r_cred   <= '0;
            r_mark   <= '0;
            r_a      <= '0;
            r_b      <= '0;
        end else begin
            r_sready <= (w_cool_nxt == '0) && (w_cred_nxt < C_W'(RESULT_DEPTH));
            r_cool   <= w_cool_nxt;
            r_cred   <= w_cred_nxt;
            r_mark   <= {r_mark[LATENCY-1:0], w_acc};
            if (w_acc) begin
                r_a <= bus.s_a;
                r_b <= bus.s_b;
            end
        end
    end

    mcp_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RESULT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr_en (r_mark[LATENCY]),
        .i_wdata (bus.adder_sum),
        .i_rd_en (w_pop),
        .o_rdata (bus.m_sum),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    a_full_means_all_credits: assert property (
        @(posedge clk) disable iff (rst) w_full |-> (r_cred == C_W'(RESULT_DEPTH))
    );

endmodule

// File: tb/tb_mcp_issue_ctrl.sv
// Randomized bench for mcp_issue_ctrl with a fixed-latency adder model
// and a queue-based transaction reference model.
module tb_mcp_issue_ctrl;
    import mcp_pkg::*;

    localparam int W   = WIDTH;
    localparam int L   = LATENCY;
    localparam int D   = RESULT_DEPTH;
    localparam int IIP = II;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mcp_issue_ctrl_if #(.WIDTH(W)) bus ();

    mcp_issue_ctrl #(
        .WIDTH        (W),
        .II           (IIP),
        .LATENCY      (L),
        .RESULT_DEPTH (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // adder: sum valid exactly L cycles after its enable cycle, junk otherwise
    logic [W-1:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= bus.adder_en ? bus.adder_a + bus.adder_b : {$urandom, $urandom};
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.adder_sum = pipe[L-1];

    typedef struct {
        logic [W-1:0] sum;
        int           rdy;
    } res_t;

    res_t         q[$];
    int           k;
    int           last_acc;
    int           outst;
    int           n_acc;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    int           n_chk;
    int           n_err;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, k, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    function automatic bit e_ready();
        return ((k - last_acc) >= IIP) && (outst < D);
    endfunction

    function automatic bit e_mvalid();
        return (q.size() > 0) && (q[0].rdy <= k);
    endfunction

    task automatic mdl_clear();
        q.delete();
        last_acc = -1000;
        outst    = 0;
        ea       = '0;
        eb       = '0;
    endtask

    task automatic cycle(input bit sv, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit mr);
        bit acc;
        bit pop;
        @(negedge clk);
        check("s_ready", bus.s_ready, e_ready());
        check("adder_en", bus.adder_en, last_acc == k - 1);
        check("adder_a", bus.adder_a, ea);
        check("adder_b", bus.adder_b, eb);
        check("m_valid", bus.m_valid, e_mvalid());
        check("busy", bus.busy, outst != 0);
        if (e_mvalid()) check("m_sum", bus.m_sum, q[0].sum);
        bus.s_valid = sv;
        bus.s_a     = a;
        bus.s_b     = b;
        bus.m_ready = mr;
        acc = sv && e_ready();
        pop = e_mvalid() && mr;
        if (pop) begin
            void'(q.pop_front());
            outst--;
        end
        if (acc) begin
            q.push_back('{sum: a + b, rdy: k + L + 2});
            last_acc = k;
            ea       = a;
            eb       = b;
            outst++;
            n_acc++;
        end
        k++;
    endtask

    task automatic chk_zero(input string t);
        check({t, "_s_ready"}, bus.s_ready, 0);
        check({t, "_adder_en"}, bus.adder_en, 0);
        check({t, "_adder_a"}, bus.adder_a, 0);
        check({t, "_adder_b"}, bus.adder_b, 0);
        check({t, "_m_valid"}, bus.m_valid, 0);
        check({t, "_m_sum"}, bus.m_sum, 0);
        check({t, "_busy"}, bus.busy, 0);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        #1;
        chk_zero("rst");
        repeat (n) begin
            @(negedge clk);
            chk_zero("rst_hold");
        end
        rst = 1'b0;
        mdl_clear();
        k++;
    endtask

    task automatic drain(input int n);
        repeat (n) cycle(1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        int got;
        int guard;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        n_chk       = 0;
        n_err       = 0;
        n_acc       = 0;
        k           = 0;
        bus.s_valid = 1'b0;
        bus.s_a     = '0;
        bus.s_b     = '0;
        bus.m_ready = 1'b0;
        mdl_clear();

        apply_reset(3);

        cycle(1'b1, 64'd5, 64'd7, 1'b1);
        drain(8);

        got   = n_acc;
        guard = 0;
        while ((n_acc - got) < 8 && guard < 100) begin
            va = W'(n_acc - got);
            cycle(1'b1, va, va << 1, 1'b1);
            guard++;
        end
        check("stream_accepts", W'(n_acc - got), 8);
        drain(10);

        repeat (16) cycle(1'b1, rnd(), rnd(), 1'b0);
        cycle(1'b1, rnd(), rnd(), 1'b1);
        repeat (6) cycle(1'b1, rnd(), rnd(), 1'b0);
        drain(30);

        repeat (5) cycle(1'b1, rnd(), rnd(), 1'b0);
        repeat (4) cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b1, rnd(), rnd(), 1'b1);
        repeat (4) cycle(1'b0, '0, '0, 1'b0);
        drain(30);

        got   = n_acc;
        guard = 0;
        while ((n_acc - got) < 3 * D && guard < 400) begin
            if (n_acc == got) begin
                va = '1;
                vb = 64'd1;
            end else begin
                va = rnd();
                vb = rnd();
            end
            cycle(1'($urandom_range(0, 3) != 0), va, vb, 1'($urandom_range(0, 1)));
            guard++;
        end
        check("wrap_accepts", W'(n_acc - got), W'(3 * D));
        drain(40);

        cycle(1'b1, 64'd11, 64'd22, 1'b1);
        cycle(1'b1, 64'd99, 64'd99, 1'b1);
        cycle(1'b1, 64'd33, 64'd44, 1'b1);
        apply_reset(1);
        drain(12);
        cycle(1'b1, 64'd5, 64'd7, 1'b1);
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mcp_issue_ctrl.md
Name: mcp_issue_ctrl

Overview:
Upstream feeder for the 2-cycle multicycle-path wide adder. Accepts operand pairs on a valid/ready stream and issues them to the adder no faster than once every II cycles. Operands are held stable across the multicycle window. Each sum is captured at its fixed latency into a small result FIFO, and results are returned on a valid/ready stream. Credit-based flow control guarantees that no result is dropped under downstream backpressure.

Parameters:
WIDTH, 64, operand and sum width (matches the adder's wide path)
II, 2, minimum cycles between adder_en pulses (>=1)
LATENCY, 3, cycles from adder_en high to adder_sum valid
RESULT_DEPTH, 4, result FIFO entries and total credit limit (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
s_valid  in  1  operand pair valid
s_ready  out  1  feeder can accept an operand pair this cycle
s_a  in  WIDTH  operand A
s_b  in  WIDTH  operand B
adder_en  out  1  registered issue strobe to the adder en input
adder_a  out  WIDTH  registered operand to adder in2
adder_b  out  WIDTH  registered operand to adder in3
adder_sum  in  WIDTH  adder out1
m_valid  out  1  result available
m_ready  in  1  downstream accepts result
m_sum  out  WIDTH  result, FIFO head
busy  out  1  credits in use != 0

Behaviour:
- Reset (async, rst=1) drives and holds every output as follows:
  - s_ready=0, adder_en=0, adder_a=0, adder_b=0, m_valid=0, m_sum=0, busy=0.
  - Cooldown counter, credit counter, latency shift register and FIFO pointers all clear.
  - s_ready rises in the first cycle after rst deasserts.
- Accept rule: s_ready = (cooldown==0) && (credits < RESULT_DEPTH). Accept = s_valid && s_ready.
  - s_ready is independent of s_valid and m_ready; there is no combinational path from m_ready to s_ready.
- Issue, for an accept in cycle t:
  - adder_a/adder_b load s_a/s_b at the end of t.
  - adder_en is 1 in cycle t+1 only.
  - adder_a/adder_b hold their value until the next accept, which keeps the adder inputs stable across its multicycle window.
- Cooldown:
  - On accept, cooldown loads II-1.
  - It decrements each cycle while nonzero.
  - With II=2: accept at t, s_ready=0 at t+1, accept possible again at t+2.
  - With II=1, back-to-back accepts are allowed.
- Capture:
  - An in-flight marker shift register, length LATENCY+1, shifts in adder_en.
  - When the marker exits at cycle t+1+LATENCY, adder_sum is written to the FIFO at the end of that cycle.
  - m_valid is 1 from cycle t+2+LATENCY. Minimum accept-to-m_valid latency is LATENCY+2 = 5 cycles.
  - The adder's own post-reset enable pulses produce 0+0 sums. These are ignored because the marker register is empty.
- Credits:
  - The counter is +1 on accept and -1 on (m_valid && m_ready).
  - Simultaneous accept and pop leave it unchanged.
  - The counter never exceeds RESULT_DEPTH, so a capture never finds the FIFO full. The FIFO must assert if overflowed in simulation.
- Output FIFO:
  - First-word-fall-through.
  - m_sum is registered and shows the head entry while m_valid=1.
  - m_sum holds its value while m_valid && !m_ready.
  - Ordering is strictly FIFO in accept order.
  - A write into an empty FIFO appears on m_valid in the following cycle.
  - Simultaneous write and read on a non-empty FIFO is allowed; occupancy is unchanged.
  - Pointers wrap modulo RESULT_DEPTH.
- Arithmetic: the feeder performs no arithmetic on data. Sums are WIDTH-bit, carry-out discarded (done by the adder).
- Reset mid-operation: all in-flight and buffered results are discarded. No m_valid occurs after reset for pre-reset accepts.

Decomposition:
- Package mcp_pkg holds the default constants WIDTH, II, LATENCY and RESULT_DEPTH, plus the function clog2-based CNT_W for the credit counter width (clog2(RESULT_DEPTH+1)).
- One sub-module: mcp_result_fifo, a parameterized WIDTH x RESULT_DEPTH FWFT FIFO with wr_en, rd_en, full, empty and an overflow assertion.
- Top level contains the accept, cooldown, credit and marker logic.

Test Plan:
- Single op: after reset, s_a=5, s_b=7 accepted at cycle 0 -> adder_en=1 at cycle 1 with adder_a=5 and adder_b=7; m_valid=1 and m_sum=12 at cycle 5.
- Streaming, II=2, m_ready=1, s_valid held high with 8 pairs (i, 2i) -> s_ready toggles 1,0,1,0...; adder_en pulses every 2 cycles; m_sum outputs 0,3,6,...,21 in order.
- Backpressure: m_ready=0 with continuous s_valid -> exactly 4 accepts, then s_ready stays 0. Raising m_ready for 1 cycle -> 1 more accept; no result is lost or reordered.
- Wrap-around: 3 * RESULT_DEPTH ops with random m_ready at 50% -> all sums correct and in order, including WIDTH overflow case 2^64-1 + 1 = 0.
- Simultaneous pop and accept at credits=RESULT_DEPTH-1 -> credit count is unchanged and s_ready stays asserted per cooldown.
- Reset mid-flight: accept 2 ops, assert rst at cycle 3 -> all outputs 0 immediately; after release no m_valid appears until a new op is accepted.
